// File: rtl/protocol_encoder_if.sv
// Parallel byte handshake into the protocol encoder.
// PROTOCOL_ENC_ERR_INJECT_EN adds a per-byte err_inject flag travelling with the handshake.
interface protocol_encoder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
`ifdef PROTOCOL_ENC_ERR_INJECT_EN
   logic       err_inject;
`endif

   // A byte transfers on the posedge where in_valid && in_ready; in_data is ignored otherwise.
`ifdef PROTOCOL_ENC_ERR_INJECT_EN
   modport master (output in_data, output in_valid, output err_inject, input in_ready);
   modport slave  (input in_data, input in_valid, input err_inject, output in_ready);
`else
   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
`endif
endinterface

// File: rtl/protocol_encoder.sv
// Byte FIFO plus serializer: frame = 0, 1, d7..d0, chk, then IDLE_GAP idle-high bits.
// Define PROTOCOL_ENC_ERR_INJECT_EN to store err_inject with each byte and invert that frame's chk.
module protocol_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int IDLE_GAP   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   protocol_encoder_if.slave             in_if,
   output logic                          serial_out,
   output logic                          busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
`ifdef PROTOCOL_ENC_ERR_INJECT_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_SYNC  = 3'd2,
      S_DATA  = 3'd3,
      S_CHK   = 3'd4,
      S_GAP   = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          chk_q, chk_d;
   logic          serial_q, serial_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          push, pop;
   logic [EW-1:0] head, wr_entry;
   logic          head_chk;

   assign in_if.in_ready = (count_q != (PW+1)'(FIFO_DEPTH));
   assign push           = in_if.in_valid & in_if.in_ready;
   assign head           = mem_q[rd_ptr_q];

   // Checksum is odd parity seeded with 1, computed once at pop time.
`ifdef PROTOCOL_ENC_ERR_INJECT_EN
   assign wr_entry = {in_if.err_inject, in_if.in_data};
   assign head_chk = ~(^head[7:0]) ^ head[8];
`else
   assign wr_entry = in_if.in_data;
   assign head_chk = ~(^head[7:0]);
`endif

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      chk_d    = chk_q;
      serial_d = serial_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (state_q == S_GAP && gap_q != GW'(IDLE_GAP - 1)) begin
               gap_d    = gap_q + GW'(1);
               serial_d = 1'b1;
            end else if (count_q != '0) begin
               // Last gap bit (or idle) leads straight into the next start bit.
               pop      = 1'b1;
               shift_d  = head[7:0];
               chk_d    = head_chk;
               serial_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_START;
            end else begin
               serial_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_START: begin
            serial_d = 1'b1;
            state_d  = S_SYNC;
         end
         S_SYNC: begin
            serial_d = shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            idx_d    = 3'd0;
            state_d  = S_DATA;
         end
         S_DATA: begin
            if (idx_q == 3'd7) begin
               serial_d = chk_q;
               done_d   = 1'b1;
               state_d  = S_CHK;
            end else begin
               serial_d = shift_q[7];
               shift_d  = {shift_q[6:0], 1'b0};
               idx_d    = idx_q + 3'd1;
            end
         end
         S_CHK: begin
            serial_d = 1'b1;
            gap_d    = '0;
            state_d  = S_GAP;
         end
         default: begin
            serial_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!push && pop) count_d = count_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         gap_q    <= '0;
         chk_q    <= 1'b0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         chk_q    <= chk_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         if (push) mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign fifo_count = count_q;
   assign dbg_state  = state_q;
endmodule
